// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmit FSM states, error codes,
// default timing constants and common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } tx_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_START_TO = 2'b01;
    localparam logic [1:0] ERR_XFER_TO  = 2'b10;
    localparam logic [1:0] ERR_NACK     = 2'b11;

    localparam int CNT_W = 20;

    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_XFER_TIMEOUT   = 100000;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge flag for one PS/2 line.
// Ports: clock, reset, line_in (raw pin) -> level (synced), fall.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle bus is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: one command byte per request.
// Ports: send_* request, tx_* status, ps2_*_in pins, ps2_*_oe drivers.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [CNT_W-1:0] INH_LAST =
        CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST =
        CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST =
        CNT_W'(XFER_TIMEOUT - 1);

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [8:0]       shreg_q, shreg_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       code_q, code_d;
    logic             ready_q;
    logic             busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
            code_q    <= code_d;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // The *_d outputs are the values seen after this edge,
    // so each branch sets the outputs of the state it moves to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        code_d    = code_q;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (send_valid) begin
                    shreg_d  = {odd_parity(send_data), send_data};
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REQ: begin
                data_oe_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                data_oe_d = 1'b1;
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    bit_idx_d = 4'd1;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end else if (cnt_q == START_LAST) begin
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    code_d    = ERR_START_TO;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SHIFT: begin
                data_oe_d = data_oe_q;
                cnt_d     = cnt_inc;
                if (cnt_q == XFER_LAST) begin
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    code_d    = ERR_XFER_TO;
                    state_d   = ST_IDLE;
                end else if (clk_fall) begin
                    if (bit_idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~shreg_q[bit_idx_q];
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                cnt_d = cnt_inc;
                if (cnt_q == XFER_LAST) begin
                    error_d = 1'b1;
                    code_d  = ERR_XFER_TO;
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    if (!data_level) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        code_d  = ERR_NACK;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = cnt_inc;
                if (cnt_q == XFER_LAST) begin
                    error_d = 1'b1;
                    code_d  = ERR_XFER_TO;
                    state_d = ST_IDLE;
                end else if (clk_level && data_level) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign send_ready  = ready_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign tx_err_code = code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
